// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline control logic.
package pipe_pkg;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Hazard controller sequencing state
  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for one EX source operand: MEM result beats WB result,
// and x0 is never forwarded because it always reads as zero.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_rd_wren,
  input  logic [4:0] wb_rd,
  input  logic       wb_rd_wren,
  output fwd_sel_e   fwd_sel
);

  // Pick the youngest in-flight producer of ex_rs
  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_rd_wren && (mem_rd != REG_X0) && (mem_rd == ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_rd_wren && (wb_rd != REG_X0) && (wb_rd == ex_rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stage enables,
// flushes, EX forwarding selects, hold watchdog and stall/flush counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int HOLD_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rd_wren,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_rd_wren,
  input  logic [4:0]       wb_rd,
  input  logic             wb_rd_wren,
  input  logic             ext_hold,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             hold_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [7:0] HOLD_MAX = 8'(HOLD_TIMEOUT);

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  hz_state_e        state_q, state_d;
  logic             pend_flush_q, pend_flush_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             hold_err_q, hold_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;

  fwd_unit u_fwd_a (
    .ex_rs       (ex_rs1),
    .mem_rd      (mem_rd),
    .mem_rd_wren (mem_rd_wren),
    .wb_rd       (wb_rd),
    .wb_rd_wren  (wb_rd_wren),
    .fwd_sel     (fwd_a)
  );

  fwd_unit u_fwd_b (
    .ex_rs       (ex_rs2),
    .mem_rd      (mem_rd),
    .mem_rd_wren (mem_rd_wren),
    .wb_rd       (wb_rd),
    .wb_rd_wren  (wb_rd_wren),
    .fwd_sel     (fwd_b)
  );

  assign load_use = ex_is_load && ex_rd_wren && (ex_rd != REG_X0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // Priority: external hold, then branch flush (live or pending), then load-use bubble
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    fwd_a_sel    = fwd_a;
    fwd_b_sel    = fwd_b;
    state_d      = state_q;
    pend_flush_d = pend_flush_q;
    hold_cnt_d   = hold_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (ext_hold) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      state_d      = HZ_HOLD;
      pend_flush_d = pend_flush_q | ex_br_taken;
      // First hold cycle restarts the count; afterwards it saturates
      if (state_q == HZ_RUN) begin
        hold_cnt_d = 8'd1;
      end else if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end
    end else begin
      state_d    = HZ_RUN;
      hold_cnt_d = 8'd0;
      if (ex_br_taken || pend_flush_q) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        pend_flush_d = 1'b0;
        flush_cnt_d  = flush_cnt_q + CNT_W'(1);
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    hold_err_d  = hold_err_q | (hold_cnt_d == HOLD_MAX);
    stall_cnt_d = pc_en ? stall_cnt_q : (stall_cnt_q + CNT_W'(1));

    // While reset is asserted the pipeline runs free with no forwarding
    if (!rst) begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b0;
      fwd_a_sel   = FWD_RF;
      fwd_b_sel   = FWD_RF;
    end
  end

  // Sequencing state, watchdog and performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HZ_RUN;
      pend_flush_q <= 1'b0;
      hold_cnt_q   <= 8'd0;
      hold_err_q   <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_flush_q <= pend_flush_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_err_q   <= hold_err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign hold_err  = hold_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by randomized traffic,
// all outputs compared against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int HT = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_rs1_used, id_rs2_used, ex_rd_wren, ex_is_load, ex_br_taken;
  logic          mem_rd_wren, wb_rd_wren, ext_hold;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, hold_err;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.HOLD_TIMEOUT(HT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd_wren(ex_rd_wren),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_rd(mem_rd), .mem_rd_wren(mem_rd_wren), .wb_rd(wb_rd), .wb_rd_wren(wb_rd_wren),
    .ext_hold(ext_hold),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .hold_err(hold_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model state
  bit          m_pend;
  int          m_hcnt;
  bit          m_err;
  logic [31:0] m_stall, m_flush;
  // Expected combinational outputs for the current cycle
  bit          e_pc, e_ifen, e_ifflush, e_idexen, e_idexflush;
  int          e_fa, e_fb;

  function automatic int fsel(input logic [4:0] rs);
    if (mem_rd_wren && mem_rd != 0 && mem_rd == rs) return 1;
    if (wb_rd_wren && wb_rd != 0 && wb_rd == rs) return 2;
    return 0;
  endfunction

  task automatic model_eval();
    bit lu;
    lu = ex_is_load && ex_rd_wren && ex_rd != 0 &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    e_pc = 1; e_ifen = 1; e_ifflush = 0; e_idexen = 1; e_idexflush = 0;
    e_fa = fsel(ex_rs1); e_fb = fsel(ex_rs2);
    if (!rst) begin
      m_pend = 0; m_hcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
      e_fa = 0; e_fb = 0;
    end else if (ext_hold) begin
      e_pc = 0; e_ifen = 0; e_idexen = 0;
    end else if (ex_br_taken || m_pend) begin
      e_ifflush = 1; e_idexflush = 1;
    end else if (lu) begin
      e_pc = 0; e_ifen = 0; e_idexflush = 1;
    end
  endtask

  task automatic model_next();
    if (!rst) return;
    if (ext_hold) begin
      if (ex_br_taken) m_pend = 1;
      if (m_hcnt < HT) m_hcnt++;
      if (m_hcnt == HT) m_err = 1;
    end else begin
      m_hcnt = 0;
      if (ex_br_taken || m_pend) begin
        m_flush++;
        m_pend = 0;
      end
    end
    if (!e_pc) m_stall++;
  endtask

  task automatic check_all();
    model_eval();
    chk("pc_en", pc_en, e_pc);
    chk("if_id_en", if_id_en, e_ifen);
    chk("if_id_flush", if_id_flush, e_ifflush);
    chk("id_ex_en", id_ex_en, e_idexen);
    chk("id_ex_flush", id_ex_flush, e_idexflush);
    chk("fwd_a_sel", fwd_a_sel, e_fa);
    chk("fwd_b_sel", fwd_b_sel, e_fb);
    chk("hold_err", hold_err, m_err);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask

  // One clock cycle: check current outputs, clock, advance the model
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_next();
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_rd_wren = 0; ex_is_load = 0; ex_br_taken = 0;
    mem_rd = 0; mem_rd_wren = 0; wb_rd = 0; wb_rd_wren = 0; ext_hold = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  int hold_left = 0;

  initial begin
    idle();
    #12;
    check_all();
    chk("rst_pc_en", pc_en, 1);
    chk("rst_flush", id_ex_flush, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Forwarding priority and x0 suppression
    ex_rd = 5; ex_rd_wren = 1; ex_rs1 = 5; mem_rd = 5; mem_rd_wren = 1; wb_rd = 5; wb_rd_wren = 1;
    #1 chk("t1_mem", fwd_a_sel, 2'b01);
    mem_rd_wren = 0;
    #1 chk("t1_wb", fwd_a_sel, 2'b10);
    ex_rs1 = 0;
    #1 chk("t1_x0", fwd_a_sel, 2'b00);
    step();

    // Load-use: one bubble, then the load moves on to MEM
    idle(); do_reset();
    ex_is_load = 1; ex_rd = 7; ex_rd_wren = 1; id_rs2 = 7; id_rs2_used = 1;
    #1 chk("t2_pc_en", pc_en, 0);
    step();
    idle(); mem_rd = 7; mem_rd_wren = 1;
    step();
    chk("t2_stall_cnt", stall_cnt, 1);

    // Taken branch beats load-use
    idle(); do_reset();
    ex_is_load = 1; ex_rd = 7; ex_rd_wren = 1; id_rs1 = 7; id_rs1_used = 1; ex_br_taken = 1;
    #1 chk("t3_pc_en", pc_en, 1);
    chk("t3_if_id_flush", if_id_flush, 1);
    step();
    idle();
    step();
    chk("t3_flush_cnt", flush_cnt, 1);
    chk("t3_stall_cnt", stall_cnt, 0);

    // Hold with a branch in its first cycle: flush applies after release
    idle(); do_reset();
    ext_hold = 1; ex_br_taken = 1;
    step();
    ex_br_taken = 0;
    step(); step();
    ext_hold = 0;
    #1 chk("t4_rel_flush", if_id_flush, 1);
    step();
    step();
    chk("t4_stall_cnt", stall_cnt, 3);
    chk("t4_flush_cnt", flush_cnt, 1);

    // Hold watchdog
    idle(); do_reset();
    ext_hold = 1;
    step(); step(); step();
    chk("t5_cyc4_err", hold_err, 0);
    step();
    chk("t5_cyc5_err", hold_err, 1);
    step(); step();
    ext_hold = 0;
    step(); step();
    chk("t5_sticky", hold_err, 1);
    do_reset();
    chk("t5_cleared", hold_err, 0);

    // Asynchronous reset during a load-use stall
    idle();
    ex_is_load = 1; ex_rd = 3; ex_rd_wren = 1; id_rs1 = 3; id_rs1_used = 1;
    #1 chk("t6_stall", pc_en, 0);
    #1 rst = 1'b0;
    #1 chk("t6_async_pc_en", pc_en, 1);
    chk("t6_async_flush", id_ex_flush, 0);
    step();
    idle(); rst = 1'b1;
    step();

    // Asynchronous reset during a hold with a pending flush
    ext_hold = 1; ex_br_taken = 1;
    step();
    ex_br_taken = 0;
    step();
    #1 rst = 1'b0;
    #1 chk("t6_hold_pc_en", pc_en, 1);
    chk("t6_hold_cnt", stall_cnt, 0);
    step();
    idle(); rst = 1'b1;
    #1 chk("t6_no_flush", if_id_flush, 0);
    step(); step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      ex_rd_wren = 1'($urandom); mem_rd_wren = 1'($urandom); wb_rd_wren = 1'($urandom);
      ex_is_load = 1'($urandom);
      ex_br_taken = ($urandom_range(0, 5) == 0);
      if (hold_left == 0 && $urandom_range(0, 11) == 0) hold_left = $urandom_range(1, 7);
      ext_hold = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
